mem_ram_clr: RTL and testbench

//  Parametrised single-clock RAM: one write port with byte enables, one

---
 rtl/mem_ram_clr_if.sv | 33 +++
 rtl/mem_ram_clr.sv | 155 +++++++++++++++
 tb/tb_mem_ram_clr.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ram_clr_if.sv
// Bus bundle for mem_ram_clr: clear control, byte-enabled write port,
// registered read port and the sticky range-error flag.
interface mem_ram_clr_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NB = WIDTH / 8;

    logic             clr_req;
    logic             busy;
    logic             we;
    logic [NB-1:0]    be;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             err;

    // Requester side: drives commands, observes status and read data.
    modport master (
        output clr_req, we, be, waddr, wdata, re, raddr,
        input  busy, rdata, rvalid, err
    );

    // RAM side.
    modport slave (
        input  clr_req, we, be, waddr, wdata, re, raddr,
        output busy, rdata, rvalid, err
    );
endinterface

// File: rtl/mem_ram_clr.sv
// Single-clock RAM with byte-enabled write, 1-cycle registered read and a
// clear engine that fills every word with CLR_VAL after reset or on request.
// Accesses to addresses >= DEPTH are dropped (write) or return zero (read)
// and raise a sticky error flag.
module mem_ram_clr #(
    parameter int unsigned     WIDTH   = 32,
    parameter int unsigned     DEPTH   = 64,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input logic          clk,
    input logic          rst_n,
    mem_ram_clr_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NB = WIDTH / 8;

    // One extra bit so DEPTH itself is representable for range compares.
    localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    // Parameter sanity checks at elaboration time.
    if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_bad_width
        $error("mem_ram_clr: WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("mem_ram_clr: DEPTH must be at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]       state_q,   state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0] rdata_q,   rdata_d;
    logic             rvalid_q,  rvalid_d;
    logic             err_q,     err_d;

    // Single internal write port shared by the clear engine and the bus.
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [NB-1:0]    mem_be;

    logic waddr_ok;
    logic raddr_ok;

    assign waddr_ok = ({1'b0, bus.waddr} < DepthW);
    assign raddr_ok = ({1'b0, bus.raddr} < DepthW);

    // Next-state: clear sweep, request handling, write/read decode.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_addr  = bus.waddr;
        mem_wdata = bus.wdata;
        mem_be    = bus.be;

        unique case (state_q)
            StClear: begin
                // Bus requests are ignored; the sweep owns the write port.
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = CLR_VAL;
                mem_be    = '1;
                if (clr_cnt_q == LastAddr) begin
                    state_d   = StReady;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            StReady: begin
                if (bus.clr_req) begin
                    // Clear wins over any same-cycle access.
                    state_d   = StClear;
                    clr_cnt_d = '0;
                    err_d     = 1'b0;
                end else begin
                    if (bus.we) begin
                        if (waddr_ok) begin
                            mem_we = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (bus.re) begin
                        rvalid_d = 1'b1;
                        if (raddr_ok) begin
                            // Old contents: the array updates at the same edge.
                            rdata_d = mem_q[bus.raddr];
                        end else begin
                            rdata_d = '0;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Control and read-port registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    // Storage array, byte-granular write; deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.busy   = (state_q == StClear);
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;

    // The sweep counter never runs past the last word, and no read can
    // complete while the engine is running.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ({1'b0, clr_cnt_q} < DepthW)
                else $error("mem_ram_clr: clr_cnt out of range");
            if (state_q == StClear) begin
                assert (!rvalid_q)
                    else $error("mem_ram_clr: rvalid during clear");
            end
        end
    end
endmodule

// File: tb/tb_mem_ram_clr.sv
// Self-checking bench for mem_ram_clr: a 64-word instance for the main
// behaviour and a 48-word instance for out-of-range accesses. Expected
// data comes from plain word arrays updated with byte-merge arithmetic.
module tb_mem_ram_clr;
    localparam int unsigned W  = 32;
    localparam int unsigned DA = 64;
    localparam int unsigned DB = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    mem_ram_clr_if #(.WIDTH(W), .DEPTH(DA)) bus_a ();
    mem_ram_clr_if #(.WIDTH(W), .DEPTH(DB)) bus_b ();

    mem_ram_clr #(.WIDTH(W), .DEPTH(DA), .CLR_VAL('0)) dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .bus   (bus_a.slave)
    );

    mem_ram_clr #(.WIDTH(W), .DEPTH(DB), .CLR_VAL('0)) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_a [DA];
    logic [31:0] model_b [DB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Outputs sampled 1 time unit after the rising edge; inputs changed there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic idle_a();
        bus_a.clr_req = 1'b0;
        bus_a.we      = 1'b0;
        bus_a.be      = '0;
        bus_a.waddr   = '0;
        bus_a.wdata   = '0;
        bus_a.re      = 1'b0;
        bus_a.raddr   = '0;
    endtask

    task automatic idle_b();
        bus_b.clr_req = 1'b0;
        bus_b.we      = 1'b0;
        bus_b.be      = '0;
        bus_b.waddr   = '0;
        bus_b.wdata   = '0;
        bus_b.re      = 1'b0;
        bus_b.raddr   = '0;
    endtask

    // Counts busy cycles from the current sample on, while hammering the
    // bus with writes and reads that must all be ignored.
    task automatic count_busy_a(output int n, output int stray);
        n     = 0;
        stray = 0;
        bus_a.we    = 1'b1;
        bus_a.be    = 4'hF;
        bus_a.waddr = '0;
        bus_a.wdata = 32'hFFFF_FFFF;
        bus_a.re    = 1'b1;
        bus_a.raddr = '0;
        while (bus_a.busy && n < 200) begin
            n++;
            if (bus_a.rvalid !== 1'b0) stray++;
            step();
        end
        idle_a();
        for (int i = 0; i < DA; i++) model_a[i] = '0;
    endtask

    task automatic count_busy_b(output int n);
        n = 0;
        while (bus_b.busy && n < 200) begin
            n++;
            step();
        end
        for (int i = 0; i < DB; i++) model_b[i] = '0;
    endtask

    task automatic write_a(input int addr, input logic [31:0] data, input logic [3:0] be);
        bus_a.we    = 1'b1;
        bus_a.waddr = 6'(addr);
        bus_a.wdata = data;
        bus_a.be    = be;
        step();
        bus_a.we    = 1'b0;
        model_a[addr] = merge(model_a[addr], data, be);
    endtask

    task automatic read_a(input int addr, output logic [31:0] data, output logic valid);
        bus_a.re    = 1'b1;
        bus_a.raddr = 6'(addr);
        step();
        data  = bus_a.rdata;
        valid = bus_a.rvalid;
        bus_a.re = 1'b0;
    endtask

    task automatic read_b(input int addr, output logic [31:0] data, output logic valid);
        bus_b.re    = 1'b1;
        bus_b.raddr = 6'(addr);
        step();
        data  = bus_b.rdata;
        valid = bus_b.rvalid;
        bus_b.re = 1'b0;
    endtask

    initial begin
        int          n;
        int          stray;
        int          bad;
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_rdata;
        logic        exp_rvalid;

        idle_a();
        idle_b();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        for (int i = 0; i < DA; i++) model_a[i] = 'x;
        for (int i = 0; i < DB; i++) model_b[i] = 'x;
        step();
        step();

        // Reset state.
        chk("reset_busy",   32'(bus_a.busy),   32'd1);
        chk("reset_rvalid", 32'(bus_a.rvalid), 32'd0);
        chk("reset_rdata",  bus_a.rdata,       32'd0);
        chk("reset_err",    32'(bus_a.err),    32'd0);

        // 1: busy for exactly DEPTH cycles, then everything reads zero.
        rst_a_n = 1'b1;
        count_busy_a(n, stray);
        chk("t1_busy_cycles", 32'(n), 32'd64);
        chk("t1_ignored_reads", 32'(stray), 32'd0);
        bad = 0;
        for (int i = 0; i < DA; i++) begin
            bus_a.re    = 1'b1;
            bus_a.raddr = 6'(i);
            step();
            if (bus_a.rdata !== 32'd0 || bus_a.rvalid !== 1'b1) bad++;
        end
        bus_a.re = 1'b0;
        chk("t1_zero_sweep_bad", 32'(bad), 32'd0);
        step();
        chk("t1_rvalid_drop", 32'(bus_a.rvalid), 32'd0);
        chk("t1_rdata_hold",  bus_a.rdata,       32'd0);

        // 2: single word write, full readback.
        write_a(10, 32'h1, 4'hF);
        bad = 0;
        for (int i = 0; i < DA; i++) begin
            read_a(i, d, v);
            if (d !== model_a[i] || v !== 1'b1) bad++;
            if (i == 10) chk("t2_addr10", d, 32'h1);
        end
        chk("t2_readback_bad", 32'(bad), 32'd0);

        // 3: byte enables.
        write_a(20, 32'h1122_3344, 4'hF);
        write_a(20, 32'hAABB_CCDD, 4'b0101);
        read_a(20, d, v);
        chk("t3_be0101", d, 32'h11BB_33DD);
        write_a(20, 32'hFFFF_FFFF, 4'h0);
        read_a(20, d, v);
        chk("t3_be0_noop", d, 32'h11BB_33DD);

        // 4: same-cycle read and write is read-first.
        write_a(5, 32'h5, 4'hF);
        bus_a.we    = 1'b1;
        bus_a.waddr = 6'd5;
        bus_a.wdata = 32'h7;
        bus_a.be    = 4'hF;
        bus_a.re    = 1'b1;
        bus_a.raddr = 6'd5;
        step();
        idle_a();
        model_a[5] = 32'h7;
        chk("t4_old_word", bus_a.rdata, 32'h5);
        chk("t4_rvalid",   32'(bus_a.rvalid), 32'd1);
        read_a(5, d, v);
        chk("t4_new_word", d, 32'h7);

        // Random traffic against the word model.
        bad = 0;
        exp_rdata = bus_a.rdata;
        for (int k = 0; k < 300; k++) begin
            int          wa;
            int          ra;
            logic [31:0] wd;
            logic [3:0]  wb;
            logic        do_w;
            logic        do_r;
            wa   = $urandom_range(0, DA - 1);
            ra   = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DA - 1);
            wd   = $urandom;
            wb   = 4'($urandom);
            do_w = 1'($urandom);
            do_r = 1'($urandom);
            bus_a.we    = do_w;
            bus_a.waddr = 6'(wa);
            bus_a.wdata = wd;
            bus_a.be    = wb;
            bus_a.re    = do_r;
            bus_a.raddr = 6'(ra);
            exp_rvalid  = do_r;
            if (do_r) exp_rdata = model_a[ra];
            if (do_w) model_a[wa] = merge(model_a[wa], wd, wb);
            step();
            if (bus_a.rdata !== exp_rdata || bus_a.rvalid !== exp_rvalid) bad++;
        end
        idle_a();
        chk("rand_mismatch_count", 32'(bad), 32'd0);
        chk("rand_err_clear", 32'(bus_a.err), 32'd0);

        // 5: clear request beats a same-cycle write.
        write_a(30, 32'h1234, 4'hF);
        bus_a.clr_req = 1'b1;
        bus_a.we      = 1'b1;
        bus_a.waddr   = 6'd10;
        bus_a.wdata   = 32'hDEAD_BEEF;
        bus_a.be      = 4'hF;
        step();
        idle_a();
        count_busy_a(n, stray);
        chk("t5_busy_cycles", 32'(n), 32'd64);
        chk("t5_ignored_reads", 32'(stray), 32'd0);
        read_a(10, d, v);
        chk("t5_addr10_clear", d, 32'h0);
        read_a(30, d, v);
        chk("t5_addr30_clear", d, 32'h0);

        // 5b: reset in the middle of a clear restarts the sweep.
        write_a(40, 32'hCAFE_F00D, 4'hF);
        write_a(0, 32'h0BAD_0BAD, 4'hF);
        bus_a.clr_req = 1'b1;
        step();
        idle_a();
        for (int i = 1; i < 20; i++) step();
        rst_a_n = 1'b0;
        step();
        chk("t5_rst_busy",   32'(bus_a.busy),   32'd1);
        chk("t5_rst_rdata",  bus_a.rdata,       32'd0);
        chk("t5_rst_rvalid", 32'(bus_a.rvalid), 32'd0);
        step();
        rst_a_n = 1'b1;
        count_busy_a(n, stray);
        chk("t5_rst_busy_cycles", 32'(n), 32'd64);
        read_a(40, d, v);
        chk("t5_addr40_clear", d, 32'h0);
        read_a(0, d, v);
        chk("t5_addr0_clear", d, 32'h0);

        // 6: non-power-of-two depth, out-of-range accesses.
        rst_b_n = 1'b1;
        count_busy_b(n);
        chk("t6_busy_cycles", 32'(n), 32'd48);
        bus_b.we    = 1'b1;
        bus_b.waddr = 6'd3;
        bus_b.wdata = 32'h55;
        bus_b.be    = 4'hF;
        step();
        model_b[3]  = 32'h55;
        chk("t6_err_inrange", 32'(bus_b.err), 32'd0);
        bus_b.waddr = 6'd50;
        bus_b.wdata = 32'hFFFF_FFFF;
        step();
        bus_b.we    = 1'b0;
        chk("t6_err_write", 32'(bus_b.err), 32'd1);
        bad = 0;
        for (int i = 0; i < DB; i++) begin
            read_b(i, d, v);
            if (d !== model_b[i] || v !== 1'b1) bad++;
        end
        chk("t6_no_change_bad", 32'(bad), 32'd0);
        read_b(3, d, v);
        chk("t6_addr3", d, 32'h55);
        read_b(50, d, v);
        chk("t6_oor_rdata",  d, 32'h0);
        chk("t6_oor_rvalid", 32'(v), 32'd1);
        chk("t6_err_sticky", 32'(bus_b.err), 32'd1);
        bus_b.clr_req = 1'b1;
        step();
        idle_b();
        chk("t6_err_cleared", 32'(bus_b.err), 32'd0);
        count_busy_b(n);
        chk("t6_clr_busy_cycles", 32'(n), 32'd48);
        read_b(3, d, v);
        chk("t6_addr3_clear", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
